// File: rtl/current_switch_array_pkg.sv
// ============================================================================
// Module  : current_switch_array_pkg
// Brief   : Shared constants and helpers for the switched current-cell array.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package current_switch_array_pkg;

    localparam int DEF_N_ARRAY    = 47;
    localparam int DEF_WIDTH      = 18;
    localparam int DEF_IN_EXP     = -14;
    localparam int DEF_OUT_EXP    = -14;
    localparam int DEF_RECIP_FRAC = 24;

    // Wide enough to hold any internal result before reduction to WIDTH bits.
    localparam int SAT_W = 128;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Round-half-up of 2^frac / n.
    function automatic longint recip(input int n, input int frac);
        return ((longint'(1) <<< frac) + longint'(n / 2)) / longint'(n);
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_trunc(
        input logic signed [SAT_W-1:0] value,
        input int                      width
    );
`ifdef CURRENT_SWITCH_ARRAY_SAT_EN
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        one = {{(SAT_W-1){1'b0}}, 1'b1};
        hi  = (one <<< (width - 1)) - one;
        lo  = -hi - one;
        if (value > hi)      return hi;
        else if (value < lo) return lo;
        else                 return value;
`else
        logic signed [SAT_W-1:0] sh;
        sh = value <<< (SAT_W - width);
        return sh >>> (SAT_W - width);
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/csa_popcount.sv
// ============================================================================
// Module  : csa_popcount
// Brief   : Combinational balanced adder-tree population count of an N-bit word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_popcount
    import current_switch_array_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]              vec_i,
    output logic [cnt_width(N)-1:0]   cnt_o
);

    localparam int OW = cnt_width(N);

    generate
        if (N == 1) begin : g_leaf
            assign cnt_o = vec_i;
        end else begin : g_node
            // Split in halves so tree depth stays log2(N).
            localparam int NL = N / 2;
            localparam int NH = N - NL;
            localparam int LW = cnt_width(NL);
            localparam int HW = cnt_width(NH);

            logic [LW-1:0] w_lo;
            logic [HW-1:0] w_hi;

            csa_popcount #(.N(NL)) u_lo (.vec_i(vec_i[NL-1:0]), .cnt_o(w_lo));
            csa_popcount #(.N(NH)) u_hi (.vec_i(vec_i[N-1:NL]), .cnt_o(w_hi));

            assign cnt_o = OW'(w_lo) + OW'(w_hi);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/current_switch_array.sv
// ============================================================================
// Module  : current_switch_array
// Brief   : v_out = v_in * popcount(ctrl) / N_ARRAY, two-stage pipeline.
//           Define CURRENT_SWITCH_ARRAY_SAT_EN to clamp instead of wrap.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module current_switch_array
    import current_switch_array_pkg::*;
#(
    parameter int N_ARRAY    = DEF_N_ARRAY,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int IN_EXP     = DEF_IN_EXP,
    parameter int OUT_EXP    = DEF_OUT_EXP,
    parameter int RECIP_FRAC = DEF_RECIP_FRAC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] v_in,
    input  logic [N_ARRAY-1:0]      ctrl,
    output logic signed [WIDTH-1:0] v_out
);

    localparam int KW  = cnt_width(N_ARRAY);
    localparam int SH  = RECIP_FRAC + OUT_EXP - IN_EXP;
    // Product magnitude < 2^(WIDTH-1+KW+RECIP_FRAC); extra bits cover sign and rounding.
    localparam int PW  = WIDTH + KW + RECIP_FRAC + 2;
    localparam int LSH = (SH < 0) ? -SH : 0;
    localparam int RW  = PW + LSH;

    localparam longint                 RECIP_L = recip(N_ARRAY, RECIP_FRAC);
    localparam logic signed [PW-1:0]   C_RECIP = PW'(RECIP_L);

    logic signed [WIDTH-1:0] v_q;
    logic [KW-1:0]           k_q;
    logic [KW-1:0]           w_k;
    logic signed [PW-1:0]    w_v_ext;
    logic signed [PW-1:0]    w_k_ext;
    logic signed [PW-1:0]    w_prod;
    logic signed [RW-1:0]    w_res;
    logic signed [SAT_W-1:0] w_sat;
    logic                    w_sat_unused;
    logic signed [WIDTH-1:0] v_out_d;
    logic signed [WIDTH-1:0] v_out_q;

    csa_popcount #(.N(N_ARRAY)) u_pop (
        .vec_i (ctrl),
        .cnt_o (w_k)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= '0;
            k_q <= '0;
        end else begin
            v_q <= v_in;
            k_q <= w_k;
        end
    end

    assign w_v_ext = PW'(v_q);
    assign w_k_ext = {{(PW-KW){1'b0}}, k_q};
    assign w_prod  = w_v_ext * w_k_ext * C_RECIP;

    generate
        if (SH > 0) begin : g_shr
            localparam logic signed [PW-1:0] C_HALF = {{(PW-1){1'b0}}, 1'b1} <<< (SH - 1);
            assign w_res = (w_prod + C_HALF) >>> SH;
        end else begin : g_shl
            logic signed [RW-1:0] w_wide;
            assign w_wide = RW'(w_prod);
            assign w_res  = w_wide <<< LSH;
        end
    endgenerate

    assign w_sat        = sat_trunc(SAT_W'(w_res), WIDTH);
    assign v_out_d      = w_sat[WIDTH-1:0];
    assign w_sat_unused = ^w_sat[SAT_W-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_out_q <= '0;
        end else begin
            v_out_q <= v_out_d;
        end
    end

    assign v_out = v_out_q;

endmodule

`default_nettype wire

// File: tb/tb_current_switch_array.sv
// ============================================================================
// Module  : tb_current_switch_array
// Brief   : Scoreboard bench for current_switch_array (default and OUT_EXP=-15).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_current_switch_array;

    localparam int N = 47;
    localparam int W = 18;
    localparam logic [N-1:0] ALL  = {N{1'b1}};
    localparam logic [N-1:0] ALT  = 47'h2AAA_AAAA_AAAA;
`ifdef CURRENT_SWITCH_ARRAY_SAT_EN
    localparam int EXP2 = 131071;
`else
    localparam int EXP2 = -3276;
`endif

    logic                clk    = 1'b0;
    logic                rst_n  = 1'b0;
    logic signed [W-1:0] v_in   = '0;
    logic signed [W-1:0] v_in2  = '0;
    logic [N-1:0]        ctrl   = '0;
    logic signed [W-1:0] v_out;
    logic signed [W-1:0] v_out2;

    int   n_chk = 0;
    int   n_err = 0;
    int   exp_q[$];
    logic iss = 1'b0;
    logic [1:0] vld = 2'b00;

    logic [N-1:0] step_c [10];
    int           step_e [10];
    logic [N-1:0] pats   [3];

    always #5 clk = ~clk;

    current_switch_array u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .v_in  (v_in),
        .ctrl  (ctrl),
        .v_out (v_out)
    );

    current_switch_array #(.OUT_EXP(-15)) u_dut15 (
        .clk   (clk),
        .rst_n (rst_n),
        .v_in  (v_in2),
        .ctrl  (ctrl),
        .v_out (v_out2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Tracks which cycles carry an issued sample through the 2-stage pipe.
    always @(posedge clk) begin
        if (!rst_n) vld <= 2'b00;
        else        vld <= {vld[0], iss};
    end

    always @(negedge clk) begin
        if (vld[1]) begin
            if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
            else                   chk("pipe", v_out, exp_q.pop_front());
        end
    end

    task automatic drive(input logic signed [W-1:0] v, input logic [N-1:0] c, input int e);
        @(negedge clk);
        v_in = v;
        ctrl = c;
        iss  = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            iss = 1'b0;
        end
    endtask

    initial begin
        step_c[0] = 47'h1;              step_e[0] = 453;
        step_c[1] = 47'h3;              step_e[1] = 906;
        step_c[2] = 47'h1F;             step_e[2] = 2266;
        step_c[3] = 47'h3FF;            step_e[3] = 4532;
        step_c[4] = ALT;                step_e[4] = 10423;
        step_c[5] = 47'hFF_FFFF;        step_e[5] = 10876;
        step_c[6] = 47'h7FFF_FFFF_FFFE; step_e[6] = 20846;
        step_c[7] = ALL;                step_e[7] = 21299;
        step_c[8] = '0;                 step_e[8] = 0;
        step_c[9] = 47'h4000_0000_0000; step_e[9] = 453;
        pats[0] = ALT;
        pats[1] = 47'h7F_FFFF;
        pats[2] = 47'h7FFF_FF00_0000;

        v_in2 = 18'sd129434;
        repeat (2) @(negedge clk);
        chk("reset_v_out", v_out, 0);
        chk("reset_v_out2", v_out2, 0);
        rst_n = 1'b1;

        repeat (10) drive(18'sd21299, ALL, 21299);
        chk("ovf_out_exp15", v_out2, EXP2);

        // Walk the enable count down from 46 to 0.
        for (int s = 1; s <= N; s++)
            repeat (10) drive(18'sd21299, ALL >> s, (2 * 21299 * (N - s) + N) / (2 * N));

        for (int p = 0; p < 3; p++)
            repeat (4) drive(18'sd21299, pats[p], 10423);

        repeat (4) drive(-18'sd21299, ALL, -21299);
        repeat (4) drive(-18'sd21299, '0, 0);
        repeat (4) drive(-18'sd21299, ALT, -10423);

        for (int i = 0; i < 10; i++)
            drive(18'sd21299, step_c[i], step_e[i]);

        repeat (4) drive(18'sd21299, ALL, 21299);
        idle(2);
        chk("pre_reset", v_out, 21299);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_clear", v_out, 0);
        rst_n = 1'b1;
        iss   = 1'b1;
        exp_q.push_back(21299);
        @(negedge clk);
        iss = 1'b0;
        chk("post_reset_gap", v_out, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
